// File: rtl/fpnew_rr_issue_arbiter_pkg.sv
// Shared types for the FPU issue arbiter: requester index sizing and
// protocol-error cause encoding.
package fpnew_arb_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned NUM_REQ = 4;

    typedef logic [idx_width(NUM_REQ)-1:0] req_idx_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_LOCK_DROP  = 2'd1,  // locked requester withdrew valid before ready
        ERR_ORPHAN_RES = 2'd2   // result arrived with no issued ID outstanding
    } err_cause_e;

endpackage

// File: rtl/fpnew_rr_issue_arbiter_if.sv
// Requester-side and unit-side handshakes of the issue arbiter.
interface fpnew_rr_issue_arbiter_if #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ResWidth  = 64
);
    localparam int unsigned IdxW = fpnew_arb_pkg::idx_width(NumReq);

    logic [NumReq-1:0]           req_valid_i;
    logic [NumReq-1:0]           req_ready_o;
    logic [NumReq*DataWidth-1:0] req_data_i;
    logic                        unit_valid_o;
    logic                        unit_ready_i;
    logic [DataWidth-1:0]        unit_data_o;
    logic [IdxW-1:0]             unit_id_o;
    logic                        unit_res_valid_i;
    logic                        unit_res_ready_o;
    logic [ResWidth-1:0]         unit_res_data_i;
    logic [NumReq-1:0]           resp_valid_o;
    logic [NumReq-1:0]           resp_ready_i;
    logic [ResWidth-1:0]         resp_data_o;
    logic                        busy_o;
    logic                        err_o;

    modport slave (
        input  req_valid_i, req_data_i, unit_ready_i, unit_res_valid_i,
               unit_res_data_i, resp_ready_i,
        output req_ready_o, unit_valid_o, unit_data_o, unit_id_o,
               unit_res_ready_o, resp_valid_o, resp_data_o, busy_o, err_o
    );

    modport master (
        output req_valid_i, req_data_i, unit_ready_i, unit_res_valid_i,
               unit_res_data_i, resp_ready_i,
        input  req_ready_o, unit_valid_o, unit_data_o, unit_id_o,
               unit_res_ready_o, resp_valid_o, resp_data_o, busy_o, err_o
    );

endinterface

// File: rtl/fpnew_rr_issue_arbiter_id_fifo.sv
// In-order FIFO of issued requester IDs; registered head, flush has priority.
module fpnew_arb_id_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic [Width-1:0]           data,
    output logic [Width-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth+1)-1:0] count
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth+1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full & ~flush_i;
    assign do_pop  = pop & ~empty & ~flush_i;

    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth-1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/fpnew_rr_issue_arbiter.sv
// Round-robin issue arbiter sharing one in-order FPU unit; an ID FIFO
// routes each result back to the requester that issued it.
module fpnew_rr_issue_arbiter
    import fpnew_arb_pkg::*;
#(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned MaxInflight = 4,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned ResWidth    = 64
) (
    input logic                     clk_i,
    input logic                     rst_i,
    input logic                     flush_i,
    fpnew_rr_issue_arbiter_if.slave bus
);
    localparam int unsigned IdxW = idx_width(NumReq);

    logic [IdxW-1:0]      ptr_q, lock_idx_q, grant, head;
    logic                 lock_q, err_q, found;
    logic                 full, empty, unit_valid, issue, stall, pop, valid_drop, orphan;
    logic [DataWidth-1:0] unit_data;
    logic [$clog2(MaxInflight+1)-1:0] count;
    err_cause_e           cause;

    // Rotating priority scan starting at ptr; a held lock overrides it.
    always_comb begin
        grant = ptr_q;
        found = 1'b0;
        if (lock_q) begin
            grant = lock_idx_q;
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                if (!found && bus.req_valid_i[IdxW'((int'(ptr_q) + k) % NumReq)]) begin
                    grant = IdxW'((int'(ptr_q) + k) % NumReq);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        unit_data = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant == IdxW'(i)) unit_data = bus.req_data_i[i*DataWidth +: DataWidth];
        end
    end

    assign unit_valid = bus.req_valid_i[grant] & ~full & ~rst_i;
    assign issue      = unit_valid & bus.unit_ready_i & ~flush_i;
    assign stall      = unit_valid & ~bus.unit_ready_i;
    assign valid_drop = lock_q & ~bus.req_valid_i[lock_idx_q];
    assign orphan     = bus.unit_res_valid_i & empty;

    assign bus.unit_valid_o = unit_valid;
    assign bus.unit_data_o  = unit_data;
    assign bus.unit_id_o    = grant;

    always_comb begin
        bus.req_ready_o  = '0;
        bus.resp_valid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            bus.req_ready_o[i]  = unit_valid & bus.unit_ready_i & (grant == IdxW'(i));
            bus.resp_valid_o[i] = bus.unit_res_valid_i & ~empty & ~rst_i & (head == IdxW'(i));
        end
    end

    assign bus.unit_res_ready_o = bus.resp_ready_i[head] & ~empty & ~rst_i;
    assign bus.resp_data_o      = bus.unit_res_data_i;
    assign pop                  = bus.unit_res_valid_i & bus.unit_res_ready_o;
    assign bus.busy_o           = (count != '0);
    assign bus.err_o            = err_q;

    always_comb begin
        cause = ERR_NONE;
        if (valid_drop)  cause = ERR_LOCK_DROP;
        else if (orphan) cause = ERR_ORPHAN_RES;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (cause != ERR_NONE) err_q <= 1'b1;
            if (flush_i) begin
                lock_q <= 1'b0;
            end else if (issue) begin
                ptr_q  <= (grant == IdxW'(NumReq-1)) ? '0 : grant + IdxW'(1);
                lock_q <= 1'b0;
            end else if (valid_drop) begin
                lock_q <= 1'b0;
            end else if (stall) begin
                lock_q     <= 1'b1;
                lock_idx_q <= grant;
            end
        end
    end

    fpnew_arb_id_fifo #(
        .Depth (MaxInflight),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push    (issue),
        .pop     (pop),
        .data    (grant),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

endmodule

// File: tb/tb_fpnew_rr_issue_arbiter.sv
// Directed plus randomized bench for the round-robin issue arbiter, checked
// against a queue-based reference model.
module tb_fpnew_rr_issue_arbiter;
    localparam int N    = 4;
    localparam int MAXI = 4;
    localparam int DW   = 64;
    localparam int RW   = 64;

    logic clk = 1'b0;
    logic rst, flush;
    always #5 clk = ~clk;

    fpnew_rr_issue_arbiter_if #(.NumReq(N), .DataWidth(DW), .ResWidth(RW)) bus ();

    fpnew_rr_issue_arbiter #(
        .NumReq(N), .MaxInflight(MAXI), .DataWidth(DW), .ResWidth(RW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    int n_tot = 0;
    int n_bad = 0;

    // reference model state
    int          m_ptr;
    bit          m_lock;
    int          m_lock_idx;
    int          m_q[$];
    bit          m_err;
    logic [63:0] dat [N];
    // predictions of the current cycle, consumed at the next edge
    bit          e_uv, e_pop;
    int          e_g;
    logic [N-1:0] e_rdy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int m_pick();
        if (m_lock) return m_lock_idx;
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (bus.req_valid_i[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_data(input int i, input logic [63:0] v);
        dat[i] = v;
        bus.req_data_i[i*DW +: DW] = v;
    endtask

    task automatic check_outputs();
        logic [N-1:0] erv;
        bit eurr;
        e_g   = m_pick();
        e_uv  = !rst && e_g >= 0 && bus.req_valid_i[e_g] && (m_q.size() < MAXI);
        e_rdy = '0;
        if (e_uv && bus.unit_ready_i) e_rdy[e_g] = 1'b1;
        erv  = '0;
        eurr = 1'b0;
        if (!rst && m_q.size() > 0) begin
            if (bus.unit_res_valid_i) erv[m_q[0]] = 1'b1;
            eurr = bus.resp_ready_i[m_q[0]];
        end
        e_pop = eurr && bus.unit_res_valid_i;
        chk("unit_valid", 64'(bus.unit_valid_o), 64'(e_uv));
        if (e_uv) begin
            chk("unit_id", 64'(bus.unit_id_o), 64'(e_g));
            chk("unit_data", bus.unit_data_o, dat[e_g]);
        end
        chk("req_ready", 64'(bus.req_ready_o), 64'(e_rdy));
        chk("resp_valid", 64'(bus.resp_valid_o), 64'(erv));
        chk("unit_res_ready", 64'(bus.unit_res_ready_o), 64'(eurr));
        chk("resp_data", bus.resp_data_o, bus.unit_res_data_i);
        if (!rst) begin
            chk("busy", 64'(bus.busy_o), 64'(m_q.size() != 0));
            chk("err", 64'(bus.err_o), 64'(m_err));
        end
    endtask

    task automatic model_update();
        bit drop;
        if (rst) begin
            m_ptr = 0; m_lock = 0; m_lock_idx = 0; m_err = 0;
            m_q.delete();
            return;
        end
        drop = m_lock && !bus.req_valid_i[m_lock_idx];
        if (bus.unit_res_valid_i && m_q.size() == 0) m_err = 1;
        if (drop) m_err = 1;
        if (flush) begin
            m_q.delete();
            m_lock = 0;
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (e_uv && bus.unit_ready_i) begin
                m_q.push_back(e_g);
                m_ptr  = (e_g + 1) % N;
                m_lock = 0;
            end else if (drop) begin
                m_lock = 0;
            end else if (e_uv) begin
                m_lock     = 1;
                m_lock_idx = e_g;
            end
        end
    endtask

    // inputs are driven at the falling edge; outputs checked 1ns later
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drain();
        bus.req_valid_i  = '0;
        bus.resp_ready_i = '1;
        for (int t = 0; t < 20 && m_q.size() > 0; t++) begin
            bus.unit_res_valid_i = 1'b1;
            bus.unit_res_data_i  = {$urandom, $urandom};
            cycle();
        end
        bus.unit_res_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] last_rdy;
        rst = 1'b1; flush = 1'b0;
        bus.req_valid_i = '1; bus.req_data_i = '0; bus.unit_ready_i = 1'b1;
        bus.unit_res_valid_i = 1'b1; bus.unit_res_data_i = '0; bus.resp_ready_i = '1;
        for (int i = 0; i < N; i++) set_data(i, {$urandom, $urandom});
        m_ptr = 0; m_lock = 0; m_lock_idx = 0; m_err = 0;
        @(negedge clk);
        // handshake outputs forced low while reset is held
        cycle(); cycle();
        rst = 1'b0; bus.req_valid_i = '0; bus.unit_res_valid_i = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        cycle();

        // T1: all valid, always ready, one result returned per cycle
        bus.req_valid_i = '1;
        for (int k = 0; k < 5; k++) begin
            bus.unit_res_valid_i = (m_q.size() != 0);
            #1 chk("t1_grant", 64'(bus.unit_id_o), 64'(k % 4));
            cycle();
        end
        drain();

        // T2: stall holds grant 1 with stable data
        bus.req_valid_i = 4'b0110; bus.unit_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t2_hold_id", 64'(bus.unit_id_o), 64'd1);
            chk("t2_hold_data", bus.unit_data_o, dat[1]);
            cycle();
        end
        bus.unit_ready_i = 1'b1;
        #1 chk("t2_fire1", 64'(bus.req_ready_o), 64'b0010);
        cycle();
        bus.req_valid_i = 4'b0100;
        #1 chk("t2_fire2", 64'(bus.req_ready_o), 64'b0100);
        cycle();
        bus.req_valid_i = '0;
        drain();

        // T3: fill the ID FIFO, pop while full does not issue
        bus.req_valid_i = '1;
        for (int k = 0; k < 4; k++) cycle();
        #1 chk("t3_full_valid", 64'(bus.unit_valid_o), 64'd0);
        chk("t3_busy", 64'(bus.busy_o), 64'd1);
        bus.unit_res_valid_i = 1'b1;
        #1 chk("t3_pop_full_valid", 64'(bus.unit_valid_o), 64'd0);
        cycle();
        bus.unit_res_valid_i = 1'b0;
        #1 chk("t3_resume", 64'(bus.unit_valid_o), 64'd1);
        cycle();
        drain();

        // T4: issue 2,0,3 then in-order routing with back-pressure
        bus.req_valid_i = 4'b0100; cycle();
        bus.req_valid_i = 4'b0001; cycle();
        bus.req_valid_i = 4'b1000; cycle();
        bus.req_valid_i = '0;
        bus.unit_res_valid_i = 1'b1;
        #1 chk("t4_route2", 64'(bus.resp_valid_o), 64'b0100);
        cycle();
        bus.resp_ready_i = 4'b1110;
        #1 chk("t4_route0", 64'(bus.resp_valid_o), 64'b0001);
        chk("t4_backpress", 64'(bus.unit_res_ready_o), 64'd0);
        cycle();
        bus.resp_ready_i = '1;
        cycle();
        #1 chk("t4_route3", 64'(bus.resp_valid_o), 64'b1000);
        cycle();
        bus.unit_res_valid_i = 1'b0;

        // T5: flush three in-flight IDs, late result is an error
        bus.req_valid_i = 4'b0111;
        for (int k = 0; k < 3; k++) cycle();
        bus.req_valid_i = '0;
        flush = 1'b1; cycle(); flush = 1'b0;
        #1 chk("t5_busy", 64'(bus.busy_o), 64'd0);
        bus.unit_res_valid_i = 1'b1;
        #1 chk("t5_no_resp", 64'(bus.resp_valid_o), 64'd0);
        cycle();
        bus.unit_res_valid_i = 1'b0;
        #1 chk("t5_err", 64'(bus.err_o), 64'd1);
        do_reset();

        // locked requester dropping valid is a protocol error
        bus.req_valid_i = 4'b0100; bus.unit_ready_i = 1'b0; cycle();
        bus.req_valid_i = '0; cycle();
        #1 chk("drop_err", 64'(bus.err_o), 64'd1);
        do_reset();

        // T6: reset while a lock is held
        bus.req_valid_i = 4'b1100; bus.unit_ready_i = 1'b0;
        cycle(); cycle();
        rst = 1'b1;
        #1 chk("t6_rst_uv", 64'(bus.unit_valid_o), 64'd0);
        chk("t6_rst_rdy", 64'(bus.req_ready_o), 64'd0);
        cycle(); cycle();
        rst = 1'b0; bus.req_valid_i = 4'b1110; bus.unit_ready_i = 1'b1;
        #1 chk("t6_first_grant", 64'(bus.unit_id_o), 64'd1);
        cycle();
        drain();

        // randomized traffic with protocol-respecting requesters
        last_rdy = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid_i[i] && last_rdy[i]) bus.req_valid_i[i] = 1'b0;
                if (!bus.req_valid_i[i] && $urandom_range(0, 2) == 0) begin
                    bus.req_valid_i[i] = 1'b1;
                    set_data(i, {$urandom, $urandom});
                end
            end
            bus.unit_ready_i     = ($urandom_range(0, 3) != 0);
            bus.resp_ready_i     = N'($urandom);
            bus.unit_res_valid_i = (m_q.size() != 0) && ($urandom_range(0, 1) == 1);
            bus.unit_res_data_i  = {$urandom, $urandom};
            flush                = ($urandom_range(0, 49) == 0);
            cycle();
            last_rdy = e_rdy;
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/fpnew_rr_issue_arbiter.md
Name: fpnew_rr_issue_arbiter

Overview:
Round-robin issue arbiter that shares one in-order FPU operation unit (a pipelined unit with a valid/ready handshake and flush) between NumReq requesters. It grants one requester per issue handshake and holds the grant stable while the unit stalls. It records each issued requester index in an in-order ID FIFO and uses that FIFO to route each result back to the requester that issued it. It sits between the per-requester issue ports and the shared unit's input and output handshakes.

Parameters:
NumReq, 4, number of requesters; must be at least 2; need not be a power of 2.
MaxInflight, 4, ID FIFO depth; must be at least (unit pipeline depth + 1) and at least 1.
DataWidth, 64, width of the operation payload forwarded to the unit.
ResWidth, 64, width of the result payload returned from the unit.
IdxW (localparam), $clog2(NumReq), width of a requester index.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset; synchronous, active-high.
flush_i  in  1  kill all in-flight operations; also driven to the shared unit.
req_valid_i  in  NumReq  per-requester issue valid.
req_ready_o  out  NumReq  per-requester issue ready.
req_data_i  in  NumReq*DataWidth  per-requester payload; requester i occupies bits [i*DataWidth +: DataWidth].
unit_valid_o  out  1  issue valid to the unit.
unit_ready_i  in  1  issue ready from the unit.
unit_data_o  out  DataWidth  payload of the granted requester.
unit_id_o  out  IdxW  granted requester index; the unit may carry it as a tag for debug.
unit_res_valid_i  in  1  result valid from the unit.
unit_res_ready_o  out  1  result ready to the unit.
unit_res_data_i  in  ResWidth  result payload from the unit.
resp_valid_o  out  NumReq  per-requester result valid; one-hot or zero.
resp_ready_i  in  NumReq  per-requester result ready.
resp_data_o  out  ResWidth  unit_res_data_i passed through combinationally.
busy_o  out  1  high when the ID FIFO is non-empty.
err_o  out  1  sticky protocol error flag.

Behaviour:
- State:
  - ptr: priority pointer, IdxW bits.
  - lock and lock_idx: grant hold.
  - ID FIFO: MaxInflight entries with count, rd and wr pointers.
  - err: sticky error register.
- Reset:
  - rst_i high at a clock edge sets ptr=0, lock=0, count=0, FIFO pointers=0, err=0.
  - While rst_i is high, unit_valid_o, req_ready_o, resp_valid_o and unit_res_ready_o are forced to 0.
  - busy_o and err_o are 0 from the first edge after reset.
  - Reset mid-operation discards all in-flight IDs. No result is routed after reset; results arriving then set err.
- Arbitration (combinational):
  - If lock=1, grant=lock_idx.
  - Otherwise, grant is the first i with req_valid_i[i]=1, scanning ptr, ptr+1, … modulo NumReq.
- Full gating: full is (count==MaxInflight), taken from registered state. When full, there is no issue, even if a result pops in the same cycle.
- Issue outputs:
  - unit_valid_o = req_valid_i[grant] & ~full & ~rst_i.
  - unit_data_o = payload of grant; unit_id_o = grant.
  - req_ready_o[grant] = unit_valid_o & unit_ready_i; all other bits are 0.
  - Issue latency is zero cycles (combinational pass-through).
- Issue handshake (unit_valid_o & unit_ready_i & ~flush_i):
  - Push grant into the FIFO.
  - ptr <= (grant==NumReq-1) ? 0 : grant+1.
  - lock <= 0.
- Stall (unit_valid_o & ~unit_ready_i): lock <= 1 and lock_idx <= grant, so the grant stays stable until the handshake.
- Requester protocol: requesters must hold valid and data until ready. A locked requester that drops valid is a protocol error; set err and clear lock.
- Result routing:
  - head is the FIFO read entry; empty is (count==0).
  - resp_valid_o[head] = unit_res_valid_i & ~empty.
  - unit_res_ready_o = resp_ready_i[head] & ~empty.
  - A result handshake pops the FIFO.
  - Result latency is zero cycles.
- Simultaneous push and pop: count stays unchanged; both pointers advance and wrap at MaxInflight.
- unit_res_valid_i while empty: set err. unit_res_ready_o stays 0 and no resp_valid_o is asserted.
- Flush:
  - flush_i at an edge clears count, FIFO pointers and lock; ptr is kept.
  - No push or pop occurs in that cycle; flush has priority over both.
  - Outputs are still driven combinationally in the flush cycle.
- busy_o = (count != 0), registered-state based.

Decomposition:
- Package fpnew_arb_pkg holds the requester index type (sized from NumReq via a function) and the protocol-error cause encoding, for use by the integration and the testbench.
- Sub-module fpnew_arb_id_fifo: a synchronous, active-high reset, flushable FIFO of IdxW-bit entries.
  - Ports: push, pop, data in, head out, full, empty, count.
  - No fall-through.
- Arbitration, locking and routing stay in the top module.

Test Plan:
1. NumReq=4, all four requesters valid continuously, unit_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles; ptr wraps 3->0.
2. Requesters 1 and 2 valid, unit_ready_i low for 3 cycles -> grant stays on 1 and unit_data_o is stable throughout; on ready, requester 1 fires and requester 2 fires next cycle.
3. MaxInflight=4, 4 issues with no results -> full; unit_valid_o=0 and busy_o=1; one result pop while full -> no issue that cycle, issue resumes the next cycle.
4. Issue order 2,0,3 with in-order results -> resp_valid_o is 0100, then 0001, then 1000; resp_ready_i[0]=0 back-pressures unit_res_ready_o to 0.
5. flush_i during 3 in-flight IDs -> count=0, busy_o=0 next cycle; a late unit_res_valid_i then sets err_o=1 and no resp_valid_o bit is set.
6. rst_i asserted mid-stream with lock held -> all handshake outputs are 0 during reset; after reset ptr=0 and the first grant goes to the lowest valid index.
